fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ requester words into one FIFO write port.
// Latency: fifo_wr/fifo_data/gnt one cycle after the deciding edge; at most one word per two cycles.
// Backpressure: fifo_full holds the FSM in IDLE with no grant. Optional macro FIFO_WR_ARB_STATS_EN adds stall_count.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]                   stall_count
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [PTR_W-1:0]   pos_idx;
  logic               win_vld;
  logic [NUM_REQ-1:0] win_onehot;
  logic [NUM_REQ-1:0] gnt_q;
  logic               decide;
  int                 pos;

  // A decision only happens in IDLE; the forced WRITE cycle gives fifo_full time to settle.
  assign decide = (state == IDLE) && (|req) && !fifo_full;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      pos_idx = PTR_W'(pos);
      if (!win_vld && req[pos_idx]) begin
        win_vld = 1'b1;
        win_idx = pos_idx;
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
    if (win_idx == PTR_W'(NUM_REQ - 1)) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (decide && win_vld) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_wr = 1'b0;
    busy    = 1'b0;
    gnt     = '0;
    if (state == WRITE) begin
      fifo_wr = 1'b1;
      busy    = 1'b1;
      gnt     = gnt_q;
    end
  end

  // Word is captured at the decision edge so later req_data changes cannot leak into the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      gnt_q     <= '0;
      fifo_data <= '0;
    end else if (decide && win_vld) begin
      ptr       <= ptr_nxt;
      gnt_q     <= win_onehot;
      fifo_data <= req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic stall;

  assign stall = (state == IDLE) && (|req) && fifo_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a depth-4 FIFO model fed by fifo_wr.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     gnt;
  logic              fifo_full;
  logic              fifo_wr;
  logic [DW-1:0]     fifo_data;
  logic              busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0]       stall_count;
`endif

  int                checks = 0;
  int                errors = 0;
  int                overflow = 0;
  logic [DW-1:0]     fq[$];
  logic              rd_req;
  logic [DW-1:0]     rd_dat;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_data  (fifo_data),
    .busy       (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stall_count(stall_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: the FIFO model acts on the strobe/data that were stable before the edge.
  task automatic tick();
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    w = fifo_wr;
    d = fifo_data;
    r = rd_req;
    @(posedge clk);
    #1;
    if (r && fq.size() > 0) rd_dat = fq.pop_front();
    if (w) begin
      if (fq.size() >= 4) overflow++;
      else fq.push_back(d);
    end
    fifo_full = (fq.size() >= 4);
  endtask

  task automatic pop_chk(input string tag, input logic [DW-1:0] exp);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check(tag, 32'(rd_dat), 32'(exp));
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    rd_req    = 1'b0;
    rd_dat    = '0;
    tick();
    check("rst_wr",   32'(fifo_wr),   32'h0);
    check("rst_gnt",  32'(gnt),       32'h0);
    check("rst_busy", 32'(busy),      32'h0);
    check("rst_data", 32'(fifo_data), 32'h00);
    reset = 1'b0;

    // single requester
    req = 4'b0001;
    req_data[7:0] = 8'hA5;
    tick();
    check("sgl_wr",   32'(fifo_wr),   32'h1);
    check("sgl_data", 32'(fifo_data), 32'hA5);
    check("sgl_gnt",  32'(gnt),       32'h1);
    check("sgl_busy", 32'(busy),      32'h1);
    req = '0;
    tick();
    check("sgl_wr_off",  32'(fifo_wr), 32'h0);
    check("sgl_gnt_off", 32'(gnt),     32'h0);
    check("sgl_busy_off", 32'(busy),   32'h0);
    pop_chk("sgl_pop", 8'hA5);

    // round robin from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    req_data = 32'h13121110;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_gnt",  32'(gnt),       32'(1 << k));
      check("rr_wr",   32'(fifo_wr),   32'h1);
      check("rr_data", 32'(fifo_data), 32'(8'h10 + k));
      tick();
      check("rr_idle_wr",  32'(fifo_wr), 32'h0);
      check("rr_idle_gnt", 32'(gnt),     32'h0);
    end

    // FIFO now full: requester 2 must stall
    req = 4'b0100;
    req_data[23:16] = 8'h77;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_gnt", 32'(gnt),     32'h0);
      check("stall_wr",  32'(fifo_wr), 32'h0);
    end
    pop_chk("stall_pop", 8'h10);
    check("stall_gnt_pop", 32'(gnt), 32'h0);
    tick();
    check("stall_rel_gnt",  32'(gnt),       32'h4);
    check("stall_rel_data", 32'(fifo_data), 32'h77);
`ifdef FIFO_WR_ARB_STATS_EN
    check("stall_count", 32'(stall_count), 32'd4);
`endif
    req = '0;
    tick();
    check("no_ovf", 32'(overflow), 32'h0);
    pop_chk("drain_11", 8'h11);
    pop_chk("drain_12", 8'h12);
    pop_chk("drain_13", 8'h13);
    pop_chk("drain_77", 8'h77);

    // pointer wrap: pointer sits at 3 after granting requester 2
    req = 4'b1000;
    req_data[31:24] = 8'hC3;
    tick();
    check("wrap_g3",   32'(gnt),       32'h8);
    check("wrap_d3",   32'(fifo_data), 32'hC3);
    req = 4'b1001;
    req_data[7:0]   = 8'hD0;
    req_data[31:24] = 8'h33;
    tick();
    check("wrap_hold", 32'(fifo_data), 32'hC3);
    check("wrap_idle", 32'(fifo_wr),   32'h0);
    tick();
    check("wrap_g0",   32'(gnt),       32'h1);
    check("wrap_d0",   32'(fifo_data), 32'hD0);
    req = 4'b1000;
    tick();
    tick();
    check("wrap_g3b",  32'(gnt),       32'h8);
    check("wrap_d3b",  32'(fifo_data), 32'h33);
    req = '0;
    tick();
    pop_chk("wrap_pop0", 8'hC3);
    pop_chk("wrap_pop1", 8'hD0);
    pop_chk("wrap_pop2", 8'h33);

    // reset in the middle of WRITE
    req = 4'b0010;
    req_data[15:8] = 8'h55;
    tick();
    check("mid_busy", 32'(busy), 32'h1);
    req = '0;
    reset = 1'b1;
    #1;
    check("mid_wr",   32'(fifo_wr),   32'h0);
    check("mid_gnt",  32'(gnt),       32'h0);
    check("mid_busy0", 32'(busy),     32'h0);
    check("mid_data", 32'(fifo_data), 32'h00);
`ifdef FIFO_WR_ARB_STATS_EN
    check("mid_stall_count", 32'(stall_count), 32'h0);
`endif
    tick();
    check("mid_nowrite", 32'(fq.size()), 32'h0);
    reset = 1'b0;
    req = 4'b0110;
    req_data[23:16] = 8'h66;
    tick();
    check("ptr_rst_gnt",  32'(gnt),       32'h2);
    check("ptr_rst_data", 32'(fifo_data), 32'h55);
    req = '0;
    tick();
    pop_chk("ptr_rst_pop", 8'h55);
    check("final_ovf", 32'(overflow), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
